multicycle_controller: RTL

- Main control FSM that turns the single-cycle core into a multicycle RV32I-subset core.
- One shared memory serves instruction fetch and data access; one ALU computes PC+4, branch and jump targets, addresses and results.
- The block decodes the latched instruction fields and sequences the datapath one state per cycle.
- ALU command encoding is the core's existing one: 000 add, 001 sub, 010 and, 011 or, 101 slt.

---
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset core: decodes the latched
// instruction fields and sequences the shared memory / single ALU datapath.
module multicycle_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       funct3_ok;
  logic [2:0] alu_dec;
  logic       pc_en, mem_en, ir_en, reg_en;

  assign state     = state_q;
  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // addi ignores instr[30]; only R-type uses it to select sub
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (state_q == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = funct3_ok ? EXECR : HALT;
          OP_I:         state_d = funct3_ok ? EXECI : HALT;
          OP_JAL:       state_d = JAL;
          OP_BR:        state_d = (funct3 == 3'b000) ? BEQ : HALT;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:                      state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:                     state_d = MEMWB;
      EXECR, EXECI, JAL:           state_d = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
      HALT:                        state_d = HALT;
      default:                     state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    adr_src     = 1'b0;
    mem_en      = 1'b0;
    ir_en       = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_en      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_en      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_en      = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_en     = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_en  = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
      end
      ALUWB: reg_en = 1'b1;
      // PC takes the target precomputed in DECODE while the ALU forms old PC+4
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_en     = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_en       = zero;
      end
      default: ;
    endcase
  end

  // Enables are masked during reset so an aborted instruction has no side effects
  assign pc_write  = pc_en  & ~rst;
  assign mem_write = mem_en & ~rst;
  assign ir_write  = ir_en  & ~rst;
  assign reg_write = reg_en & ~rst;
  assign illegal   = (state_q == HALT) & ~rst;

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule
